// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: decode-side reads and issue,
// writeback-side write, plus the registered busy population count.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with per-register busy scoreboard,
// optional write-to-read bypass and optional hard-wired zero register.
module regfile_mp_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_RD      = 2,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS      = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_mp_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   busy_cnt_q;
    logic              wr_ok;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // A write to r0 is dropped entirely when r0 is hard-wired, including for bypass.
    assign wr_ok = bus.wr_en && !((ZERO_REG_EN != 0) && (bus.wr_addr == '0));

    // Issue is applied after release so a new producer wins over a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (bus.iss_en) begin
            busy_nxt[bus.iss_addr] = 1'b1;
        end
        if (ZERO_REG_EN != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_ok) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
            busy       <= busy_nxt;
            busy_cnt_q <= popcount(busy_nxt);
        end
    end

    assign bus.busy_cnt = busy_cnt_q;

    // Bypass is gated by rst_n so reads stay zero while reset is held.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic [NUM_RD*DATA_W-1:0] rd_data_c;
        logic [NUM_RD-1:0]        rd_busy_c;
        a         = '0;
        hit       = 1'b0;
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a   = bus.rd_addr[k*ADDR_W +: ADDR_W];
            hit = (BYPASS != 0) && rst_n && wr_ok && (bus.wr_addr == a);
            rd_data_c[k*DATA_W +: DATA_W] = hit ? bus.wr_data : mem[a];
            rd_busy_c[k]                  = hit ? 1'b0 : busy[a];
        end
        bus.rd_data = rd_data_c;
        bus.rd_busy = rd_busy_c;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one instance with bypass, one without,
// both driven from the same stimulus.
module tb_regfile_mp_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    regfile_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();
    regfile_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus_nb ();

    assign bus_nb.rd_addr  = bus.rd_addr;
    assign bus_nb.wr_en    = bus.wr_en;
    assign bus_nb.wr_addr  = bus.wr_addr;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.iss_en   = bus.iss_en;
    assign bus_nb.iss_addr = bus.iss_addr;

    regfile_mp_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                    .ZERO_REG_EN(1), .BYPASS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    regfile_mp_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                    .ZERO_REG_EN(1), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rdd(input int k);
        return bus.rd_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rdd_nb(input int k);
        return bus_nb.rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        bus.rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic idle_inputs();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
    endtask

    task automatic test_reset_power();
        set_rd(0, 5'd5);
        set_rd(1, 5'd7);
        #1;
        if (rdd(0) !== 32'h0) begin
            $display("FAIL por_rd_data got %h want %h", rdd(0), 32'h0); n_err++;
        end
        n_vec++;
        if (bus.busy_cnt !== 6'd0) begin
            $display("FAIL por_busy_cnt got %0d want 0", bus.busy_cnt); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_async();
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        set_rd(0, 5'd5); set_rd(1, 5'd7);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        if (rdd(0) !== 32'hDEADBEEF) begin
            $display("FAIL pre_rst_r5 got %h want %h", rdd(0), 32'hDEADBEEF); n_err++;
        end
        n_vec++;
        if (bus.rd_busy[1] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            $display("FAIL pre_rst_busy got %b/%0d want 1/1", bus.rd_busy[1], bus.busy_cnt); n_err++;
        end
        n_vec++;
        #1 rst_n = 1'b0;
        #1;
        if (rdd(0) !== 32'h0) begin
            $display("FAIL async_rst_r5 got %h want %h", rdd(0), 32'h0); n_err++;
        end
        n_vec++;
        if (bus.rd_busy[1] !== 1'b0 || bus.busy_cnt !== 6'd0) begin
            $display("FAIL async_rst_busy got %b/%0d want 0/0", bus.rd_busy[1], bus.busy_cnt); n_err++;
        end
        n_vec++;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hCAFE0001;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        #1;
        if (rdd(0) !== 32'h0 || bus.rd_busy[1] !== 1'b0) begin
            $display("FAIL rst_bypass got %h/%b want 0/0", rdd(0), bus.rd_busy[1]); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        if (rdd(0) !== 32'h0 || bus.busy_cnt !== 6'd0) begin
            $display("FAIL rst_discard got %h/%0d want 0/0", rdd(0), bus.busy_cnt); n_err++;
        end
        n_vec++;
        idle_inputs();
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_zero_reg();
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h12345678;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        set_rd(0, 5'd0); set_rd(1, 5'd0);
        #2;
        if (rdd(0) !== 32'h0) begin
            $display("FAIL r0_bypass got %h want %h", rdd(0), 32'h0); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        if (rdd(0) !== 32'h0 || rdd(1) !== 32'h0) begin
            $display("FAIL r0_data got %h/%h want 0/0", rdd(0), rdd(1)); n_err++;
        end
        n_vec++;
        if (bus.rd_busy !== 2'b00 || bus.busy_cnt !== 6'd0) begin
            $display("FAIL r0_busy got %b/%0d want 00/0", bus.rd_busy, bus.busy_cnt); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_bypass();
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h11;
        @(posedge clk); #1;
        bus.wr_data = 32'h22;
        set_rd(0, 5'd3); set_rd(1, 5'd3);
        #2;
        if (rdd(0) !== 32'h22 || rdd(1) !== 32'h22) begin
            $display("FAIL bypass_on got %h/%h want 22/22", rdd(0), rdd(1)); n_err++;
        end
        n_vec++;
        if (rdd_nb(0) !== 32'h11 || rdd_nb(1) !== 32'h11) begin
            $display("FAIL bypass_off_old got %h/%h want 11/11", rdd_nb(0), rdd_nb(1)); n_err++;
        end
        n_vec++;
        if (bus.rd_busy !== 2'b00) begin
            $display("FAIL bypass_busy got %b want 00", bus.rd_busy); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        if (rdd_nb(0) !== 32'h22 || rdd_nb(1) !== 32'h22) begin
            $display("FAIL bypass_off_new got %h/%h want 22/22", rdd_nb(0), rdd_nb(1)); n_err++;
        end
        n_vec++;
        if (bus.busy_cnt !== 6'd0) begin
            $display("FAIL wr_nonbusy_cnt got %0d want 0", bus.busy_cnt); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_scoreboard();
        @(posedge clk); #1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        set_rd(0, 5'd9); set_rd(1, 5'd9);
        @(posedge clk); #1;
        if (bus.rd_busy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
            $display("FAIL sb_issue got %b/%0d want 1/1", bus.rd_busy[0], bus.busy_cnt); n_err++;
        end
        n_vec++;
        bus.iss_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5;
        #2;
        if (bus_nb.rd_busy[0] !== 1'b1 || bus.rd_busy[0] !== 1'b0) begin
            $display("FAIL sb_wb_cycle got nb=%b byp=%b want 1/0", bus_nb.rd_busy[0], bus.rd_busy[0]); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        if (bus.rd_busy !== 2'b00 || bus.busy_cnt !== 6'd0) begin
            $display("FAIL sb_release got %b/%0d want 00/0", bus.rd_busy, bus.busy_cnt); n_err++;
        end
        n_vec++;
        if (rdd(0) !== 32'hA5 || rdd_nb(1) !== 32'hA5) begin
            $display("FAIL sb_data got %h/%h want a5/a5", rdd(0), rdd_nb(1)); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_collision();
        @(posedge clk); #1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        set_rd(0, 5'd9); set_rd(1, 5'd10);
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h5A;
        #2;
        if (rdd(0) !== 32'h5A || bus.rd_busy[0] !== 1'b0) begin
            $display("FAIL coll_bypass got %h/%b want 5a/0", rdd(0), bus.rd_busy[0]); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        bus.iss_addr = 5'd10;
        bus.wr_data  = 32'h77;
        #1;
        if (bus_nb.rd_busy[0] !== 1'b1 || rdd_nb(0) !== 32'h5A || bus.busy_cnt !== 6'd1) begin
            $display("FAIL coll_set_wins got %b/%h/%0d want 1/5a/1",
                     bus_nb.rd_busy[0], rdd_nb(0), bus.busy_cnt); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        bus.iss_en = 1'b0;
        bus.wr_addr = 5'd10; bus.wr_data = 32'h99;
        #1;
        if (bus_nb.rd_busy !== 2'b10 || rdd_nb(0) !== 32'h77 || bus.busy_cnt !== 6'd1) begin
            $display("FAIL diff_addr got %b/%h/%0d want 10/77/1",
                     bus_nb.rd_busy, rdd_nb(0), bus.busy_cnt); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        if (bus.busy_cnt !== 6'd0 || rdd(1) !== 32'h99) begin
            $display("FAIL coll_cleanup got %0d/%h want 0/99", bus.busy_cnt, rdd(1)); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_full();
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            if (bus.busy_cnt !== 6'(i - 1)) begin
                $display("FAIL full_issue_cnt r%0d got %0d want %0d", i, bus.busy_cnt, i - 1); n_err++;
            end
            n_vec++;
            bus.iss_en = 1'b1; bus.iss_addr = 5'(i);
        end
        @(posedge clk); #1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        #1;
        if (bus.busy_cnt !== 6'd31) begin
            $display("FAIL full_cnt got %0d want 31", bus.busy_cnt); n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        idle_inputs();
        if (bus.busy_cnt !== 6'd31) begin
            $display("FAIL reissue_busy got %0d want 31", bus.busy_cnt); n_err++;
        end
        n_vec++;
        for (int i = 1; i < 32; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'(i);
            bus.wr_data = 32'hC0DE0000 + 32'(i * 257);
            @(posedge clk); #1;
            if (bus.busy_cnt !== 6'(31 - i)) begin
                $display("FAIL full_release_cnt r%0d got %0d want %0d", i, bus.busy_cnt, 31 - i); n_err++;
            end
            n_vec++;
        end
        idle_inputs();
        for (int i = 1; i < 32; i++) begin
            set_rd(0, 5'(i));
            set_rd(1, 5'(32 - i));
            #1;
            if (rdd(0) !== 32'hC0DE0000 + 32'(i * 257) ||
                rdd(1) !== 32'hC0DE0000 + 32'((32 - i) * 257)) begin
                $display("FAIL full_data r%0d got %h/%h want %h/%h", i, rdd(0), rdd(1),
                         32'hC0DE0000 + 32'(i * 257), 32'hC0DE0000 + 32'((32 - i) * 257)); n_err++;
            end
            n_vec++;
            if (bus.rd_busy !== 2'b00) begin
                $display("FAIL full_busy r%0d got %b want 00", i, bus.rd_busy); n_err++;
            end
            n_vec++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.rd_addr = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset_power();
        @(negedge clk) rst_n = 1'b1;
        test_reset_async();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
